// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared definitions for the PLL clock sequencer: the FSM state type, the
// width of the relock event counter, and a small constant helper used to
// size the shared phase counter.
package pll_seq_pkg;

  // Width of the saturating relock_count output.
  localparam int RELOCK_W = 8;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_ENABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  // Largest of three elaboration-time limits.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic 1-bit two-flop synchroniser for an asynchronous level input.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, parks both stages low
//   d     - asynchronous input
//   q     - synchronised output (two destination cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d;
  logic meta_q;
  logic sync_d;
  logic sync_q;

  // Next value of each stage: the chain simply shifts the input through.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser stages; reset reports "not asserted" until the input is resampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_clk_sequencer.sv
// pll_clk_sequencer
// Sequences a PLL from reset to running: pulses the PLL reset, qualifies the
// (synchronised) lock with a stability window, enables the output clock gates
// one channel at a time, and restarts on lock loss with a bounded retry budget.
// Ports:
//   clkin        - free-running board clock, the only clock
//   reset        - synchronous active-high reset
//   pll_lock     - raw asynchronous PLL lock
//   ch_req       - per-channel enable request
//   retry        - single-cycle pulse that leaves FAIL
//   pll_reset    - PLL RESET pin
//   enclk        - PLL ENCLKn gate enables
//   ready        - all requested channels enabled with lock qualified
//   fail         - retry budget exhausted
//   relock_count - saturating count of lock losses seen while running
module pll_clk_sequencer
  import pll_seq_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int EN_STAGGER   = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                pll_lock,
  input  logic [N_CH-1:0]     ch_req,
  input  logic                retry,
  output logic                pll_reset,
  output logic [N_CH-1:0]     enclk,
  output logic                ready,
  output logic                fail,
  output logic [RELOCK_W-1:0] relock_count
);

  // One phase counter is shared by the reset pulse, lock timeout and stagger
  // delay, since only one of them is active in any state.
  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, EN_STAGGER)) + 1;
  localparam int STB_W = $clog2(LOCK_STABLE) + 1;
  localparam int RTY_W = $clog2(MAX_RETRY) + 1;

  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]    STG_LAST   = CNT_W'(EN_STAGGER - 1);
  localparam logic [CNT_W-1:0]    TO_LIMIT   = CNT_W'(LOCK_TIMEOUT);
  localparam logic [STB_W-1:0]    STB_ONE    = STB_W'(1);
  localparam logic [STB_W-1:0]    STB_LIMIT  = STB_W'(LOCK_STABLE);
  localparam logic [RTY_W-1:0]    RTY_ONE    = RTY_W'(1);
  localparam logic [RTY_W-1:0]    RTY_LIMIT  = RTY_W'(MAX_RETRY);
  localparam logic [N_CH-1:0]     CH_ONE     = N_CH'(1);
  localparam logic [RELOCK_W-1:0] RELOCK_ONE = RELOCK_W'(1);

  logic lock_s;

  pll_state_e            state_d,     state_q;
  logic [CNT_W-1:0]      cnt_d,       cnt_q;
  logic [STB_W-1:0]      stable_d,    stable_q;
  logic [RTY_W-1:0]      retry_cnt_d, retry_cnt_q;
  logic [N_CH-1:0]       en_mask_d,   en_mask_q;
  logic                  pll_reset_d, pll_reset_q;
  logic [N_CH-1:0]       enclk_d,     enclk_q;
  logic                  ready_d,     ready_q;
  logic                  fail_d,      fail_q;
  logic [RELOCK_W-1:0]   relock_d,    relock_q;

  logic [STB_W-1:0]      stable_nxt;
  logic [CNT_W-1:0]      timeout_nxt;
  logic [RTY_W-1:0]      retry_nxt;

  sync_2ff u_lock_sync (
    .clk   (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state and registered-output decode for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stable_d    = stable_q;
    retry_cnt_d = retry_cnt_q;
    en_mask_d   = en_mask_q;
    pll_reset_d = pll_reset_q;
    enclk_d     = '0;
    ready_d     = 1'b0;
    fail_d      = fail_q;
    relock_d    = relock_q;
    stable_nxt  = '0;
    timeout_nxt = '0;
    retry_nxt   = '0;

    case (state_q)
      ST_RST_PLL: begin
        pll_reset_d = 1'b1;
        en_mask_d   = '0;
        if (cnt_q == RST_LAST) begin
          state_d     = ST_WAIT_LOCK;
          pll_reset_d = 1'b0;
          cnt_d       = '0;
          stable_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT_LOCK: begin
        stable_nxt  = lock_s ? (stable_q + STB_ONE) : '0;
        timeout_nxt = cnt_q + CNT_ONE;
        stable_d    = stable_nxt;
        cnt_d       = timeout_nxt;
        // Stability is tested first so it wins a tie with the timeout.
        if (stable_nxt == STB_LIMIT) begin
          state_d   = ST_ENABLE;
          cnt_d     = '0;
          en_mask_d = CH_ONE;
        end else if (timeout_nxt == TO_LIMIT) begin
          retry_nxt   = retry_cnt_q + RTY_ONE;
          retry_cnt_d = retry_nxt;
          cnt_d       = '0;
          pll_reset_d = 1'b1;
          if (retry_nxt == RTY_LIMIT) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = ST_RST_PLL;
          end
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end

      ST_ENABLE: begin
        if (!lock_s) begin
          state_d     = ST_RST_PLL;
          pll_reset_d = 1'b1;
          cnt_d       = '0;
          en_mask_d   = '0;
        end else begin
          enclk_d = en_mask_q & ch_req;
          if (cnt_q == STG_LAST) begin
            cnt_d = '0;
            // The mask fills from bit 0 upward, so the top bit marks the last channel.
            if (en_mask_q[N_CH-1]) begin
              state_d     = ST_RUN;
              ready_d     = 1'b1;
              retry_cnt_d = '0;
            end else begin
              en_mask_d = (en_mask_q << 1'b1) | CH_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_RUN: begin
        if (!lock_s) begin
          state_d     = ST_RST_PLL;
          pll_reset_d = 1'b1;
          cnt_d       = '0;
          en_mask_d   = '0;
          if (relock_q != '1) begin
            relock_d = relock_q + RELOCK_ONE;
          end else begin
            relock_d = relock_q;
          end
        end else begin
          enclk_d = ch_req;
          ready_d = 1'b1;
        end
      end

      ST_FAIL: begin
        pll_reset_d = 1'b1;
        fail_d      = 1'b1;
        if (retry) begin
          state_d     = ST_RST_PLL;
          fail_d      = 1'b0;
          retry_cnt_d = '0;
          cnt_d       = '0;
        end else begin
          state_d = ST_FAIL;
        end
      end

      default: begin
        state_d     = ST_RST_PLL;
        pll_reset_d = 1'b1;
        cnt_d       = '0;
        en_mask_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_RST_PLL;
      cnt_q       <= '0;
      stable_q    <= '0;
      retry_cnt_q <= '0;
      en_mask_q   <= '0;
      pll_reset_q <= 1'b1;
      enclk_q     <= '0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      relock_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      retry_cnt_q <= retry_cnt_d;
      en_mask_q   <= en_mask_d;
      pll_reset_q <= pll_reset_d;
      enclk_q     <= enclk_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      relock_q    <= relock_d;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign enclk        = enclk_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// tb_pll_clk_sequencer
// Self-checking bench for pll_clk_sequencer with small timing parameters:
// a cycle vector table, hand-written multi-cycle sequences, and a randomized
// run compared against a behavioural model of the sequencing rules.
module tb_pll_clk_sequencer;

  localparam int N_CH         = 3;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int EN_STAGGER   = 2;
  localparam int MAX_RETRY    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic [2:0] ch_req;
  logic       retry;
  logic       pll_reset;
  logic [2:0] enclk;
  logic       ready;
  logic       fail;
  logic [7:0] relock_count;

  int total = 0;
  int bad   = 0;

  pll_clk_sequencer #(
    .N_CH        (N_CH),
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .EN_STAGGER  (EN_STAGGER),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clkin       (clk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .ch_req      (ch_req),
    .retry       (retry),
    .pll_reset   (pll_reset),
    .enclk       (enclk),
    .ready       (ready),
    .fail        (fail),
    .relock_count(relock_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: inputs already set are sampled at the posedge, outputs read at the negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic measure(input logic level, output int n);
    n = 0;
    while (pll_reset === level && n < 200) begin
      n++;
      cyc();
    end
  endtask

  task automatic wait_change(input logic [2:0] prev, output int n);
    n = 0;
    while (enclk === prev && n < 60) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    chk(nm, ready, 1);
  endtask

  // Drop the lock pin for one cycle, then wait until the drop has taken effect.
  task automatic drop_lock();
    pll_lock = 1'b0;
    cyc();
    pll_lock = 1'b1;
    cyc();
    cyc();
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int PH_PULSE = 0, PH_LOCKWAIT = 1, PH_STAGGER = 2, PH_RUN = 3, PH_DEAD = 4;
  int         m_ph, m_el, m_stab, m_tries, m_relocks;
  bit         m_s1, m_s2;
  bit         m_prst, m_ready, m_fail;
  logic [2:0] m_en;

  task automatic m_step(input bit r, input bit pin, input logic [2:0] req, input bit rt);
    bit ls;
    int nb;
    ls = m_s2;
    if (r) begin
      m_ph = PH_PULSE; m_el = 0; m_stab = 0; m_tries = 0; m_relocks = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
      m_prst = 1'b1; m_en = 3'b000; m_ready = 1'b0; m_fail = 1'b0;
      return;
    end
    m_s2 = m_s1;
    m_s1 = pin;
    m_en = 3'b000;
    m_ready = 1'b0;
    case (m_ph)
      PH_PULSE: begin
        m_el++;
        if (m_el == RST_CYCLES) begin
          m_ph = PH_LOCKWAIT; m_el = 0; m_stab = 0; m_prst = 1'b0;
        end
      end
      PH_LOCKWAIT: begin
        m_el++;
        m_stab = ls ? m_stab + 1 : 0;
        if (m_stab == LOCK_STABLE) begin
          m_ph = PH_STAGGER; m_el = 0;
        end else if (m_el == LOCK_TIMEOUT) begin
          m_tries++;
          m_prst = 1'b1;
          m_el = 0;
          if (m_tries == MAX_RETRY) begin
            m_ph = PH_DEAD; m_fail = 1'b1;
          end else begin
            m_ph = PH_PULSE;
          end
        end
      end
      PH_STAGGER: begin
        if (!ls) begin
          m_ph = PH_PULSE; m_el = 0; m_prst = 1'b1;
        end else begin
          // Channels enabled so far grow by one every EN_STAGGER cycles.
          nb = m_el / EN_STAGGER + 1;
          if (nb > N_CH) nb = N_CH;
          m_en = 3'((1 << nb) - 1) & req;
          m_el++;
          if (m_el == N_CH * EN_STAGGER) begin
            m_ph = PH_RUN; m_ready = 1'b1; m_tries = 0;
          end
        end
      end
      PH_RUN: begin
        if (!ls) begin
          m_ph = PH_PULSE; m_el = 0; m_prst = 1'b1;
          m_relocks = (m_relocks < 255) ? m_relocks + 1 : 255;
        end else begin
          m_en = req;
          m_ready = 1'b1;
        end
      end
      PH_DEAD: begin
        if (rt) begin
          m_ph = PH_PULSE; m_el = 0; m_fail = 1'b0; m_tries = 0;
        end
      end
      default: m_ph = PH_PULSE;
    endcase
  endtask

  typedef struct {
    logic       rst;
    logic       lock;
    logic [2:0] req;
    logic       rty;
    logic [5:0] exp;  // {pll_reset, enclk, ready, fail}
  } vec_t;

  vec_t tv[21];

  initial begin
    int         n;
    int         idx;
    int         seen;
    logic [2:0] e_en;
    int         seg_left;
    bit         seg_val;

    // Masked-channel start: lock high throughout, ch_req=101 then 111 in RUN.
    for (int k = 0; k < 21; k++) begin
      tv[k].rst  = (k == 0);
      tv[k].lock = 1'b1;
      tv[k].req  = (k >= 19) ? 3'b111 : 3'b101;
      tv[k].rty  = 1'b0;
      e_en = (k < 13) ? 3'b000 : (k < 17) ? 3'b001 : (k < 19) ? 3'b101 : 3'b111;
      tv[k].exp  = {((k < 4) ? 1'b1 : 1'b0), e_en, ((k >= 18) ? 1'b1 : 1'b0), 1'b0};
    end

    reset = 1'b1; pll_lock = 1'b0; ch_req = 3'b111; retry = 1'b0;
    @(negedge clk);

    // ---- clean start ----
    do_reset();
    chk("t1_reset_outs", {pll_reset, enclk, ready, fail}, 6'b1_000_0_0);
    chk("t1_reset_relock", relock_count, 0);
    measure(1'b1, n);
    chk("t1_pulse_len", n, RST_CYCLES);
    repeat (6) cyc();
    pll_lock = 1'b1;
    wait_change(3'b000, n);
    chk("t1_first_en", enclk, 3'b001);
    wait_change(3'b001, n);
    chk("t1_gap1", n, EN_STAGGER);
    chk("t1_second_en", enclk, 3'b011);
    wait_change(3'b011, n);
    chk("t1_gap2", n, EN_STAGGER);
    chk("t1_third_en", enclk, 3'b111);
    wait_ready("t1_ready");
    chk("t1_relock", relock_count, 0);

    // ---- vector table ----
    for (int k = 0; k < 21; k++) begin
      reset = tv[k].rst; pll_lock = tv[k].lock; ch_req = tv[k].req; retry = tv[k].rty;
      cyc();
      chk($sformatf("vec_%0d", k), {pll_reset, enclk, ready, fail}, tv[k].exp);
    end

    // ---- glitchy lock: stable window completes on the same cycle as the timeout ----
    ch_req = 3'b111; pll_lock = 1'b0;
    do_reset();
    idx = 0; seen = 0;
    for (int c = 0; c < 30; c++) begin
      pll_lock = (c % 5 == 0) ? 1'b0 : 1'b1;
      cyc();
      idx++;
      if (idx >= 4 && pll_reset === 1'b1) seen++;
    end
    pll_lock = 1'b1;
    while (enclk === 3'b000 && idx < 80) begin
      cyc();
      idx++;
      if (idx >= 4 && pll_reset === 1'b1) seen++;
    end
    chk("t2_first_en_cycle", idx, 37);
    chk("t2_no_retry_pulse", seen, 0);
    chk("t2_no_fail", fail, 0);
    wait_ready("t2_ready");

    // ---- lock loss in RUN ----
    pll_lock = 1'b0;
    cyc();
    pll_lock = 1'b1;
    chk("t4_e1", {enclk, ready}, 4'b111_1);
    cyc();
    chk("t4_e2", {enclk, ready}, 4'b111_1);
    cyc();
    chk("t4_e3", {pll_reset, enclk, ready}, 5'b1_000_0);
    chk("t4_relock1", relock_count, 1);
    wait_ready("t4_reseq");
    for (int i = 2; i <= 300; i++) begin
      drop_lock();
      wait_ready($sformatf("t4_reseq_%0d", i));
      if (i == 200) chk("t4_relock200", relock_count, 200);
      if (i == 255) chk("t4_relock255", relock_count, 255);
    end
    chk("t4_relock_sat", relock_count, 255);

    // ---- reset during ENABLE ----
    drop_lock();
    n = 0;
    while (enclk !== 3'b011 && n < 100) begin
      cyc();
      n++;
    end
    chk("t6_reach_011", enclk, 3'b011);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_outs", {pll_reset, enclk, ready, fail}, 6'b1_000_0_0);
    chk("t6_relock", relock_count, 0);

    // ---- timeout to FAIL and retry ----
    pll_lock = 1'b0;
    do_reset();
    measure(1'b1, n); chk("t3_pulse1", n, RST_CYCLES);
    measure(1'b0, n); chk("t3_wait1", n, LOCK_TIMEOUT);
    chk("t3_fail_early", fail, 0);
    measure(1'b1, n); chk("t3_pulse2", n, RST_CYCLES);
    measure(1'b0, n); chk("t3_wait2", n, LOCK_TIMEOUT);
    chk("t3_fail", {pll_reset, fail}, 2'b11);
    pll_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ch_req = 3'($urandom);
      cyc();
    end
    chk("t3_fail_held", {pll_reset, enclk, ready, fail}, 6'b1_000_0_1);
    retry = 1'b1;
    cyc();
    retry = 1'b0;
    chk("t3_retry_clear", {pll_reset, fail}, 2'b10);
    measure(1'b1, n); chk("t3_pulse3", n, RST_CYCLES);

    // ---- randomized run against the model ----
    seg_left = 0; seg_val = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      reset = (k == 0) || ($urandom_range(0, 499) == 0);
      if (seg_left == 0) begin
        seg_val  = ($urandom_range(0, 3) != 0);
        seg_left = seg_val ? $urandom_range(5, 80) : $urandom_range(1, 50);
      end
      seg_left--;
      pll_lock = seg_val;
      ch_req   = 3'($urandom);
      retry    = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      m_step(reset, pll_lock, ch_req, retry);
      @(negedge clk);
      chk($sformatf("rand_%0d", k), {pll_reset, enclk, ready, fail, relock_count},
          {m_prst, m_en, m_ready, m_fail, 8'(m_relocks)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
